// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access stage of the RV32 pipeline. It takes the execute-stage
//   ALU result as the effective address and drives a req/gnt/rvalid
//   data-memory port. It aligns store data onto byte lanes and extracts and
//   extends load data. Results go to writeback through a registered
//   valid/ready handshake.
//
// Ports
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   E_valid_i / M_ready_o   execute -> stage handshake (M_ready_o is combinational)
//   E_valE_i                ALU result / effective address
//   E_store_data_i          rs2 store data
//   E_load_i, E_store_i     op type (load wins if both are set)
//   E_size_i, E_unsigned_i  access size (00 b, 01 h, 1x w), zero-extend select
//   E_rd_i, E_rd_we_i       destination register and its write enable
//   dmem_*                  data-memory request port
//   M_valid_o / W_ready_i   stage -> writeback handshake
//   M_rd_o, M_rd_we_o       destination to writeback (we forced 0 on store/misalign)
//   M_valM_o                load data, or the ALU result for other ops
//   M_misalign_o            misaligned access; no bus cycle was issued
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | empty, ready to accept
// REQ   | dmem_req_o high, bus fields held until dmem_gnt_i
// RESP  | load granted, waiting for dmem_rvalid_i
// OUT   | result presented to writeback until W_ready_i

module mem_access_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              E_valid_i,
  output logic              M_ready_o,
  input  logic [XLEN-1:0]   E_valE_i,
  input  logic [XLEN-1:0]   E_store_data_i,
  input  logic              E_load_i,
  input  logic              E_store_i,
  input  logic [1:0]        E_size_i,
  input  logic              E_unsigned_i,
  input  logic [4:0]        E_rd_i,
  input  logic              E_rd_we_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  output logic [3:0]        dmem_be_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              M_valid_o,
  input  logic              W_ready_i,
  output logic [4:0]        M_rd_o,
  output logic              M_rd_we_o,
  output logic [XLEN-1:0]   M_valM_o,
  output logic              M_misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

  state_t            state;
  logic [XLEN-1:0]   val_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              rd_we_q;
  logic              load_q;

  logic              accept;
  logic              e_load;
  logic              e_store;
  logic              e_mem;
  logic              e_misalign;
  logic [3:0]        e_be;
  logic [XLEN-1:0]   e_wdata;
  logic [XLEN-1:0]   rd_shift;
  logic [XLEN-1:0]   load_ext;

  assign M_ready_o   = (state == IDLE) | ((state == OUT) & W_ready_i);
  assign accept      = E_valid_i & M_ready_o;
  assign dmem_addr_o = {val_q[ADDR_W-1:2], 2'b00};

  assign e_load  = E_load_i;
  assign e_store = E_store_i & ~E_load_i;
  assign e_mem   = e_load | e_store;

  always_comb begin
    e_misalign = 1'b0;
    e_be       = 4'b1111;
    e_wdata    = E_store_data_i;
    case (E_size_i)
      2'b00: begin
        e_be    = 4'b0001 << E_valE_i[1:0];
        e_wdata = {4{E_store_data_i[7:0]}};
      end
      2'b01: begin
        e_misalign = E_valE_i[0];
        e_be       = 4'b0011 << E_valE_i[1:0];
        e_wdata    = {2{E_store_data_i[15:0]}};
      end
      default: begin
        e_misalign = (E_valE_i[1:0] != 2'b00);
      end
    endcase
  end

  // Move the addressed lane down to bit 0 first so that one extender
  // serves every byte offset.
  always_comb begin
    rd_shift = dmem_rdata_i >> {val_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_ext = uns_q ? {{(XLEN-8){1'b0}}, rd_shift[7:0]}
                                : {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_ext = uns_q ? {{(XLEN-16){1'b0}}, rd_shift[15:0]}
                                : {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      val_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      rd_we_q      <= 1'b0;
      load_q       <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= '0;
      M_valid_o    <= 1'b0;
      M_rd_o       <= '0;
      M_rd_we_o    <= 1'b0;
      M_valM_o     <= '0;
      M_misalign_o <= 1'b0;
    end else if (accept) begin
      val_q        <= E_valE_i;
      size_q       <= E_size_i;
      uns_q        <= E_unsigned_i;
      rd_we_q      <= E_rd_we_i;
      load_q       <= e_load;
      M_rd_o       <= E_rd_i;
      M_valM_o     <= E_valE_i;
      M_misalign_o <= 1'b0;
      // Read cycles carry no byte strobes; the lane is picked on return.
      dmem_we_o    <= e_store & ~e_misalign;
      dmem_be_o    <= (e_store & ~e_misalign) ? e_be : 4'b0000;
      dmem_wdata_o <= (e_store & ~e_misalign) ? e_wdata : '0;
      if (!e_mem) begin
        state     <= OUT;
        M_valid_o <= 1'b1;
        M_rd_we_o <= E_rd_we_i;
      end else if (e_misalign) begin
        state        <= OUT;
        M_valid_o    <= 1'b1;
        M_rd_we_o    <= 1'b0;
        M_misalign_o <= 1'b1;
      end else begin
        state      <= REQ;
        dmem_req_o <= 1'b1;
        M_valid_o  <= 1'b0;
        M_rd_we_o  <= 1'b0;
      end
    end else begin
      case (state)
        REQ: begin
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            if (load_q) begin
              state <= RESP;
            end else begin
              state     <= OUT;
              M_valid_o <= 1'b1;
              M_rd_we_o <= 1'b0;
            end
          end
        end
        RESP: begin
          if (dmem_rvalid_i) begin
            state     <= OUT;
            M_valM_o  <= load_ext;
            M_rd_we_o <= rd_we_q;
            M_valid_o <= 1'b1;
          end
        end
        OUT: begin
          if (W_ready_i) begin
            state     <= IDLE;
            M_valid_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: the bench plays execute, memory and
// writeback, and checks outputs 1 ns after each rising edge.

module tb_mem_access_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        E_valid_i;
  logic        M_ready_o;
  logic [31:0] E_valE_i;
  logic [31:0] E_store_data_i;
  logic        E_load_i;
  logic        E_store_i;
  logic [1:0]  E_size_i;
  logic        E_unsigned_i;
  logic [4:0]  E_rd_i;
  logic        E_rd_we_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        M_valid_o;
  logic        W_ready_i;
  logic [4:0]  M_rd_o;
  logic        M_rd_we_o;
  logic [31:0] M_valM_o;
  logic        M_misalign_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  mem_access_stage #(.XLEN(32), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .E_valid_i(E_valid_i), .M_ready_o(M_ready_o),
    .E_valE_i(E_valE_i), .E_store_data_i(E_store_data_i),
    .E_load_i(E_load_i), .E_store_i(E_store_i),
    .E_size_i(E_size_i), .E_unsigned_i(E_unsigned_i),
    .E_rd_i(E_rd_i), .E_rd_we_i(E_rd_we_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .M_valid_o(M_valid_o), .W_ready_i(W_ready_i),
    .M_rd_o(M_rd_o), .M_rd_we_o(M_rd_we_o),
    .M_valM_o(M_valM_o), .M_misalign_o(M_misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic op(input logic ld, input logic st, input logic [1:0] sz,
                    input logic uns, input logic [31:0] va, input logic [31:0] sd,
                    input logic [4:0] rd, input logic we);
    E_valid_i      = 1'b1;
    E_load_i       = ld;
    E_store_i      = st;
    E_size_i       = sz;
    E_unsigned_i   = uns;
    E_valE_i       = va;
    E_store_data_i = sd;
    E_rd_i         = rd;
    E_rd_we_i      = we;
  endtask

  task automatic idle_in();
    E_valid_i = 1'b0;
    E_load_i  = 1'b0;
    E_store_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0;
    idle_in();
    E_valE_i = '0; E_store_data_i = '0; E_size_i = '0; E_unsigned_i = 1'b0;
    E_rd_i = '0; E_rd_we_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    W_ready_i = 1'b1;
    cyc(); cyc();
    chk("rst_ready", M_ready_o, 1);
    chk("rst_req",   dmem_req_o, 0);
    chk("rst_valid", M_valid_o, 0);
    chk("rst_valM",  M_valM_o, 0);
    rst_n_i = 1'b1;
    cyc();

    // back-to-back non-memory ops
    op(0, 0, 2'b10, 0, 32'h1234, 0, 5'd3, 1);
    cyc();
    chk("nm1_valid", M_valid_o, 1);
    chk("nm1_valM",  M_valM_o, 32'h1234);
    chk("nm1_rdwe",  M_rd_we_o, 1);
    chk("nm1_ready", M_ready_o, 1);
    E_valE_i = 32'h5678;
    cyc();
    chk("nm2_valM",  M_valM_o, 32'h5678);
    chk("nm2_valid", M_valid_o, 1);
    chk("nm2_ready", M_ready_o, 1);
    idle_in();
    cyc();
    chk("nm_idle_valid", M_valid_o, 0);

    // lb @0x1003, gnt after two wait cycles; rvalid during REQ is ignored
    op(1, 0, 2'b00, 0, 32'h1003, 0, 5'd5, 1);
    cyc();
    idle_in();
    chk("lb_req1",  dmem_req_o, 1);
    chk("lb_addr1", dmem_addr_o, 32'h1000);
    chk("lb_be1",   dmem_be_o, 4'b0000);
    chk("lb_we1",   dmem_we_o, 0);
    chk("lb_ready_req", M_ready_o, 0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
    cyc();
    dmem_rvalid_i = 1'b0;
    chk("lb_req2",  dmem_req_o, 1);
    chk("lb_addr2", dmem_addr_o, 32'h1000);
    chk("lb_be2",   dmem_be_o, 4'b0000);
    cyc();
    chk("lb_req3",  dmem_req_o, 1);
    chk("lb_addr3", dmem_addr_o, 32'h1000);
    dmem_gnt_i = 1'b1;
    cyc();
    dmem_gnt_i = 1'b0;
    chk("lb_resp_req",   dmem_req_o, 0);
    chk("lb_resp_valid", M_valid_o, 0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FF_0000;
    cyc();
    dmem_rvalid_i = 1'b0;
    chk("lb_valid", M_valid_o, 1);
    chk("lb_valM",  M_valM_o, 32'hFFFF_FF80);
    chk("lb_rd",    M_rd_o, 5'd5);
    chk("lb_rdwe",  M_rd_we_o, 1);
    cyc();
    chk("lb_done_valid", M_valid_o, 0);

    // lbu @0x1003, immediate gnt, result held with W_ready low for 4 cycles
    op(1, 0, 2'b00, 1, 32'h1003, 0, 5'd6, 1);
    cyc();
    idle_in();
    dmem_gnt_i = 1'b1;
    cyc();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FF_0000;
    W_ready_i = 1'b0;
    cyc();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = 32'hFFFF_FFFF;
    op(0, 0, 2'b10, 0, 32'h1111, 0, 5'd7, 1);
    for (int i = 0; i < 4; i++) begin
      chk("lbu_hold_valid", M_valid_o, 1);
      chk("lbu_hold_valM",  M_valM_o, 32'h0000_0080);
      chk("lbu_hold_ready", M_ready_o, 0);
      if (i < 3) cyc();
    end
    W_ready_i = 1'b1;
    #1;
    chk("lbu_release_ready", M_ready_o, 1);
    cyc();
    idle_in();
    chk("b2b_valM",  M_valM_o, 32'h1111);
    chk("b2b_rd",    M_rd_o, 5'd7);
    chk("b2b_valid", M_valid_o, 1);
    cyc();

    // sh @0x2002
    op(0, 1, 2'b01, 0, 32'h2002, 32'hDEAD_BEEF, 5'd8, 1);
    cyc();
    idle_in();
    chk("sh_req",   dmem_req_o, 1);
    chk("sh_we",    dmem_we_o, 1);
    chk("sh_addr",  dmem_addr_o, 32'h2000);
    chk("sh_be",    dmem_be_o, 4'b1100);
    chk("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
    dmem_gnt_i = 1'b1;
    cyc();
    dmem_gnt_i = 1'b0;
    chk("sh_out_valid", M_valid_o, 1);
    chk("sh_out_rdwe",  M_rd_we_o, 0);
    chk("sh_out_req",   dmem_req_o, 0);
    cyc();

    // sb @0x2001
    op(0, 1, 2'b00, 0, 32'h2001, 32'h0000_12AB, 5'd9, 1);
    cyc();
    idle_in();
    chk("sb_be",    dmem_be_o, 4'b0010);
    chk("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
    dmem_gnt_i = 1'b1;
    cyc();
    dmem_gnt_i = 1'b0;
    cyc();

    // misaligned lw @0x3001 and lh @0x3003
    op(1, 0, 2'b10, 0, 32'h3001, 0, 5'd10, 1);
    cyc();
    chk("mis_lw_req",   dmem_req_o, 0);
    chk("mis_lw_flag",  M_misalign_o, 1);
    chk("mis_lw_rdwe",  M_rd_we_o, 0);
    chk("mis_lw_valid", M_valid_o, 1);
    op(1, 0, 2'b01, 0, 32'h3003, 0, 5'd11, 1);
    cyc();
    chk("mis_lh_flag", M_misalign_o, 1);
    chk("mis_lh_req",  dmem_req_o, 0);
    op(0, 0, 2'b10, 0, 32'h3003, 0, 5'd12, 1);
    cyc();
    idle_in();
    chk("mis_clear", M_misalign_o, 0);
    cyc();

    // load and store both set -> load; lh sign extension from upper half
    op(1, 1, 2'b01, 0, 32'h6002, 32'hFFFF_FFFF, 5'd13, 1);
    cyc();
    idle_in();
    chk("ldst_we", dmem_we_o, 0);
    chk("ldst_be", dmem_be_o, 4'b0000);
    dmem_gnt_i = 1'b1;
    cyc();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8001_7777;
    cyc();
    dmem_rvalid_i = 1'b0;
    chk("lh_valM", M_valM_o, 32'hFFFF_8001);
    chk("lh_rdwe", M_rd_we_o, 1);
    cyc();

    // reset while a store request is pending drops req immediately
    op(0, 1, 2'b10, 0, 32'h7000, 32'h0BAD_F00D, 5'd14, 0);
    cyc();
    idle_in();
    chk("sw_req", dmem_req_o, 1);
    chk("sw_be",  dmem_be_o, 4'b1111);
    rst_n_i = 1'b0;
    #2;
    chk("rstreq_req",   dmem_req_o, 0);
    chk("rstreq_ready", M_ready_o, 1);
    cyc();
    rst_n_i = 1'b1;
    cyc();

    // reset mid-RESP, then a stray rvalid must not produce a result
    op(1, 0, 2'b10, 0, 32'h4000, 0, 5'd15, 1);
    cyc();
    idle_in();
    dmem_gnt_i = 1'b1;
    cyc();
    dmem_gnt_i = 1'b0;
    chk("rresp_valid_pre", M_valid_o, 0);
    rst_n_i = 1'b0;
    #2;
    chk("rresp_req",   dmem_req_o, 0);
    chk("rresp_valid", M_valid_o, 0);
    chk("rresp_ready", M_ready_o, 1);
    cyc();
    rst_n_i = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_CAFE;
    cyc();
    dmem_rvalid_i = 1'b0;
    chk("stray_valid", M_valid_o, 0);
    chk("stray_ready", M_ready_o, 1);
    cyc();
    chk("stray_valid2", M_valid_o, 0);
    chk("stray_req",    dmem_req_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
